// File: rtl/f_ifu_fd_pkg.sv
// Shared fetch-stage constants and the F/D pipeline payload.
package f_ifu_fd_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned EXC_W    = 5;

    localparam logic [XLEN-1:0]  PC_RESET = 32'h0000_3000;
    localparam logic [XLEN-1:0]  IM_BASE  = 32'h0000_3000;
    localparam logic [XLEN-1:0]  IM_TOP   = 32'h0000_6FFC;

    localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;

    // Contents of the F/D pipeline register
    typedef struct packed {
        logic [XLEN-1:0]  instr;
        logic [XLEN-1:0]  pc;
        logic [EXC_W-1:0] exc;
        logic             bd;
    } fd_t;

endpackage

// File: rtl/f_adel_chk.sv
// Combinational instruction-fetch address checker: alignment and IM range.
module f_adel_chk
    import f_ifu_fd_pkg::*;
(
    input  logic [XLEN-1:0]  i_pc,
    output logic             o_adel,
    output logic [EXC_W-1:0] o_exc_code
);

    logic w_misaligned;
    logic w_out_of_range;

    assign w_misaligned   = (i_pc[1:0] != 2'b00);
    assign w_out_of_range = (i_pc < IM_BASE) || (i_pc > IM_TOP);
    assign o_adel         = w_misaligned || w_out_of_range;
    assign o_exc_code     = o_adel ? EXC_ADEL : EXC_INT;

endmodule

// File: rtl/f_ifu_fd.sv
// Fetch stage: fetch PC register, fetch address check and the F/D pipeline register.
module f_ifu_fd
    import f_ifu_fd_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   NPC_in,
    input  logic              stall,
    input  logic              req,
    input  logic              jump_D,
    input  logic [XLEN-1:0]   IM_rdata,
    output logic [XLEN-1:0]   PC_F,
    output logic [XLEN-1:0]   Instr_D,
    output logic [XLEN-1:0]   PC_D,
    output logic [XLEN-1:0]   PC4_D,
    output logic [EXC_W-1:0]  ExcCode_D,
    output logic              BD_D
);

    logic [XLEN-1:0]  r_pc;
    fd_t              r_fd;
    logic [XLEN-1:0]  w_pc_next;
    fd_t              w_fd_next;
    logic             w_adel_f;
    logic [EXC_W-1:0] w_exc_f;
    logic [XLEN-1:0]  w_instr_f;

    f_adel_chk u_adel_chk (
        .i_pc       (r_pc),
        .o_adel     (w_adel_f),
        .o_exc_code (w_exc_f)
    );

    // A faulting fetch becomes a nop so IM data never leaks past a bad address
    assign w_instr_f = w_adel_f ? '0 : IM_rdata;

    // Next-state selection; redirect beats stall
    always_comb begin
        w_pc_next = r_pc;
        w_fd_next = r_fd;
        if (req) begin
            w_pc_next       = NPC_in;
            w_fd_next       = '0;
            w_fd_next.pc    = NPC_in;
        end else if (!stall) begin
            w_pc_next       = NPC_in;
            w_fd_next.instr = w_instr_f;
            w_fd_next.pc    = r_pc;
            w_fd_next.exc   = w_exc_f;
            w_fd_next.bd    = jump_D;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= PC_RESET;
            r_fd <= '0;
        end else begin
            r_pc <= w_pc_next;
            r_fd <= w_fd_next;
        end
    end

    assign PC_F      = r_pc;
    assign Instr_D   = r_fd.instr;
    assign PC_D      = r_fd.pc;
    assign ExcCode_D = r_fd.exc;
    assign BD_D      = r_fd.bd;
    assign PC4_D     = r_fd.pc + XLEN'(4);

endmodule

// File: tb/tb_f_ifu_fd.sv
// Directed self-checking bench for f_ifu_fd.
module tb_f_ifu_fd;

    logic        clk;
    logic        reset;
    logic [31:0] NPC_in;
    logic        stall;
    logic        req;
    logic        jump_D;
    logic [31:0] IM_rdata;
    logic [31:0] PC_F;
    logic [31:0] Instr_D;
    logic [31:0] PC_D;
    logic [31:0] PC4_D;
    logic [4:0]  ExcCode_D;
    logic        BD_D;

    logic        use_force;
    logic [31:0] im_force;

    int checks   = 0;
    int failures = 0;

    f_ifu_fd dut (
        .clk       (clk),
        .reset     (reset),
        .NPC_in    (NPC_in),
        .stall     (stall),
        .req       (req),
        .jump_D    (jump_D),
        .IM_rdata  (IM_rdata),
        .PC_F      (PC_F),
        .Instr_D   (Instr_D),
        .PC_D      (PC_D),
        .PC4_D     (PC4_D),
        .ExcCode_D (ExcCode_D),
        .BD_D      (BD_D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: address-dependent word
    function automatic logic [31:0] im_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5A5, a[15:0]};
    endfunction

    assign IM_rdata = use_force ? im_force : im_word(PC_F);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_d(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [4:0] exc, input logic bd);
        chk({tag, ".Instr_D"}, Instr_D, instr);
        chk({tag, ".PC_D"}, PC_D, pc);
        chk({tag, ".PC4_D"}, PC4_D, pc + 32'd4);
        chk({tag, ".ExcCode_D"}, 32'(ExcCode_D), 32'(exc));
        chk({tag, ".BD_D"}, 32'(BD_D), 32'(bd));
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; req = 1'b0; jump_D = 1'b0;
        NPC_in = 32'h0; use_force = 1'b0; im_force = 32'h0;
        #22;
        chk("rst.PC_F", PC_F, 32'h3000);
        chk_d("rst", 32'h0, 32'h0, 5'd0, 1'b0);

        // Sequential fetch after reset release (released away from an edge)
        @(posedge clk); #2;
        reset = 1'b1; NPC_in = 32'h3004;
        step();
        chk("seq1.PC_F", PC_F, 32'h3004);
        chk_d("seq1", im_word(32'h3000), 32'h3000, 5'd0, 1'b0);
        NPC_in = 32'h3008;
        step();
        chk("seq2.PC_F", PC_F, 32'h3008);
        chk_d("seq2", im_word(32'h3004), 32'h3004, 5'd0, 1'b0);
        NPC_in = 32'h3010;
        step();
        chk("seq3.PC_F", PC_F, 32'h3010);

        // Two stalled cycles hold everything
        stall = 1'b1; NPC_in = 32'h3014;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall.PC_F", PC_F, 32'h3010);
            chk_d("stall", im_word(32'h3008), 32'h3008, 5'd0, 1'b0);
        end
        stall = 1'b0;
        step();
        chk("unstall.PC_F", PC_F, 32'h3014);
        chk_d("unstall", im_word(32'h3010), 32'h3010, 5'd0, 1'b0);

        // Misaligned and out-of-range fetches, then the IM_TOP boundary
        NPC_in = 32'h3012;
        step();
        chk("mis.PC_F", PC_F, 32'h3012);
        use_force = 1'b1; im_force = 32'h1234_5678;
        NPC_in = 32'h7000;
        step();
        chk_d("mis", 32'h0, 32'h3012, 5'd4, 1'b0);
        NPC_in = 32'h6FFC;
        step();
        chk_d("oor", 32'h0, 32'h7000, 5'd4, 1'b0);
        NPC_in = 32'h2FFC;
        step();
        chk_d("top", 32'h1234_5678, 32'h6FFC, 5'd0, 1'b0);
        NPC_in = 32'h3020;
        step();
        chk_d("below", 32'h0, 32'h2FFC, 5'd4, 1'b0);
        use_force = 1'b0;

        // Branch-delay flag tracks jump_D at the fetch edge
        NPC_in = 32'h3024;
        step();
        chk("bd.PC_F", PC_F, 32'h3024);
        jump_D = 1'b1; NPC_in = 32'h3028;
        step();
        chk_d("bd1", im_word(32'h3024), 32'h3024, 5'd0, 1'b1);
        jump_D = 1'b0; NPC_in = 32'h302C;
        step();
        chk_d("bd0", im_word(32'h3028), 32'h3028, 5'd0, 1'b0);

        // Redirect with stall and jump_D asserted: req wins and flushes
        req = 1'b1; stall = 1'b1; jump_D = 1'b1; NPC_in = 32'h4180;
        step();
        chk("req1.PC_F", PC_F, 32'h4180);
        chk_d("req1", 32'h0, 32'h4180, 5'd0, 1'b0);
        NPC_in = 32'h4200;
        step();
        chk("req2.PC_F", PC_F, 32'h4200);
        chk_d("req2", 32'h0, 32'h4200, 5'd0, 1'b0);
        req = 1'b0; stall = 1'b0; jump_D = 1'b0; NPC_in = 32'h4204;
        step();
        chk("post.PC_F", PC_F, 32'h4204);
        chk_d("post", im_word(32'h4200), 32'h4200, 5'd0, 1'b0);

        // Asynchronous reset in the middle of a stall
        NPC_in = 32'h3040;
        step();
        chk("pre.PC_F", PC_F, 32'h3040);
        stall = 1'b1; req = 1'b1; NPC_in = 32'h5000;
        #1;
        reset = 1'b0;
        #1;
        chk("arst.PC_F", PC_F, 32'h3000);
        chk_d("arst", 32'h0, 32'h0, 5'd0, 1'b0);
        stall = 1'b0; req = 1'b0; NPC_in = 32'h3004;
        step();
        reset = 1'b1;
        step();
        chk("rel.PC_F", PC_F, 32'h3004);
        chk_d("rel", im_word(32'h3000), 32'h3000, 5'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/f_ifu_fd.md
Name: f_ifu_fd

Overview:
- Fetch-stage unit for the 5-stage MIPS pipeline.
- Holds the architectural fetch PC (PC_F) and checks each fetch for address exceptions.
- Carries the fetched instruction into Decode through the F/D pipeline register.
- Consumes the next-PC value from the Decode next-PC logic; produces PC_F for that logic, plus the PC, PC+4, instruction, exception code and branch-delay flag used in Decode.

Parameters:
- PC_RESET, 32'h0000_3000, fetch PC after reset.
- IM_BASE, 32'h0000_3000, lowest legal instruction address.
- IM_TOP, 32'h0000_6FFC, highest legal word-aligned instruction address.
- EXC_ADEL, 5'd4, ExcCode for an instruction-fetch address error.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- NPC_in  in  32  next PC from the Decode next-PC logic.
- stall  in  1  hazard stall; holds PC_F and the F/D register.
- req  in  1  exception/interrupt or eret redirect; flushes F/D and loads NPC_in.
- jump_D  in  1  instruction currently in D is a branch or jump.
- IM_rdata  in  32  instruction memory read data at PC_F (combinational memory).
- PC_F  out  32  current fetch address (to IM and next-PC logic).
- Instr_D  out  32  instruction in Decode.
- PC_D  out  32  PC of the instruction in Decode.
- PC4_D  out  32  PC_D + 4.
- ExcCode_D  out  5  fetch exception code carried to Decode; 0 = none.
- BD_D  out  1  instruction in Decode is a branch delay slot.

Behaviour:
- Reset, asynchronous, while reset == 0:
  - PC_F = PC_RESET.
  - Instr_D = 0, PC_D = 0, ExcCode_D = 0, BD_D = 0.
  - PC4_D = 4, since it is derived from PC_D.
- Release of reset takes effect on the next rising edge; no synchronizer inside the block.
- Fetch check (combinational on PC_F):
  - adel_F = (PC_F[1:0] != 0) OR (PC_F < IM_BASE) OR (PC_F > IM_TOP).
  - Instr_F = adel_F ? 0 : IM_rdata, so the faulting fetch becomes a nop.
  - ExcCode_F = adel_F ? EXC_ADEL : 0.
- PC register, per rising edge, priority req > stall > normal:
  - req = 1: PC_F <= NPC_in, even if stall = 1.
  - stall = 1: PC_F holds.
  - otherwise: PC_F <= NPC_in.
- F/D register, same priority:
  - req = 1: Instr_D <= 0, ExcCode_D <= 0, BD_D <= 0, PC_D <= NPC_in. The bubble carries the handler PC so a later EPC capture is correct.
  - stall = 1: all D outputs hold.
  - otherwise: Instr_D <= Instr_F, PC_D <= PC_F, ExcCode_D <= ExcCode_F, BD_D <= jump_D.
- PC4_D = PC_D + 4, combinational, modulo 2^32.
- Latency: an instruction at PC_F appears in Decode one cycle after its fetch cycle, when not stalled.
- Boundary conditions:
  - PC_F = IM_TOP, not stalled: the fetch is legal; the next PC (IM_TOP + 4) raises AdEL when fetched.
  - Misaligned NPC_in (e.g. from jr): no trap at load; AdEL is flagged in the cycle that address is fetched, and reaches D one edge later.
  - PC wrap 0xFFFF_FFFC + 4 -> 0: not generated here; the out-of-range check flags it as AdEL.
  - req and stall in the same cycle: req wins.
  - Several req cycles in a row: each edge reloads NPC_in and re-flushes.
  - Reset mid-stall or mid-req: reset values apply immediately; pending stall/req are discarded.
- No X propagation: IM_rdata is masked when adel_F = 1.

Decomposition:
- Shared constants in const.v: PC_RESET value, IM_BASE, IM_TOP, and the ExcCode encodings (EXC_INT = 0, EXC_ADEL = 4, etc.), used by this block, CP0 and the M/W stages.
- One sub-module is natural: f_adel_chk, the combinational fetch-address checker (PC -> adel, ExcCode). Everything else stays in f_ifu_fd.

Test Plan:
- Reset, then release with stall = 0, req = 0, NPC_in = PC_F + 4 -> PC_F reads 3000, 3004, 3008 on successive edges; Instr_D equals IM_rdata fetched at 3000 one edge later; PC4_D = 3004.
- stall = 1 for 2 cycles with PC_F = 3010 -> PC_F stays 3010 and D outputs are unchanged for both cycles; both advance on the first unstalled edge.
- PC_F = 3012 (misaligned), IM_rdata = 0x1234_5678 -> next edge: Instr_D = 0, ExcCode_D = 4, PC_D = 3012. Repeat with PC_F = 7000 -> ExcCode_D = 4.
- req = 1 and stall = 1, NPC_in = 4180 -> next edge: PC_F = 4180, PC_D = 4180, Instr_D = 0, ExcCode_D = 0, BD_D = 0.
- jump_D = 1 while the instruction at 3024 is fetched -> next edge: PC_D = 3024, BD_D = 1. Next unstalled fetch with jump_D = 0 -> BD_D = 0.
- Assert reset while stall = 1 and PC_F = 3040 -> PC_F = 3000 and all D outputs return to reset values without waiting for a clock edge.
